universal_shift_register: RTL and testbench

- Parametrised successor to the single-bit DFF register: a WIDTH-bit register with synchronous clear, parallel load, and shift/rotate operations.
- Two ways to operate it:
  - Direct mode: one operation per enabled cycle while the controller is idle.
  - Command mode: a start/busy/done handshake that performs a multi-step shift of `amount` positions.
- Used as the datapath shifter for lab-level serial/parallel conversion and shift-based arithmetic.

---
 rtl/universal_shift_register_pkg.sv | 26 ++
 rtl/universal_shift_register_if.sv | 27 ++
 rtl/universal_shift_register_shift_step.sv | 52 +++++
 rtl/universal_shift_register.sv | 81 ++++++++
 tb/tb_universal_shift_register.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: operation codes, controller
// states and a helper that tells which operations take part in multi-step commands.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    ASR  = 3'd6
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only shifts and rotates can be repeated; HOLD, LOAD and code 7 finish at once.
  function automatic logic is_multi_step(input logic [2:0] m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Operation/command bus of the universal shift register; the controller side
// uses the master modport and the register uses the slave modport.
interface usr_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             enable;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output enable, mode, serial_in, load_data, start, amount,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  enable, mode, serial_in, load_data, start, amount,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/universal_shift_register_shift_step.sv
// One combinational step of the register: computes the next contents and the
// bit pushed out, shared by direct operations and command steps.
module shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             out_valid
);

  always_comb begin
    next_q    = q;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    case (mode)
      LOAD: next_q = load_data;
      SHL: begin
        next_q    = {q[WIDTH-2:0], serial_in};
        out_bit   = q[WIDTH-1];
        out_valid = 1'b1;
      end
      SHR: begin
        next_q    = {serial_in, q[WIDTH-1:1]};
        out_bit   = q[0];
        out_valid = 1'b1;
      end
      ROL: begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit   = q[WIDTH-1];
        out_valid = 1'b1;
      end
      ROR: begin
        next_q    = {q[0], q[WIDTH-1:1]};
        out_bit   = q[0];
        out_valid = 1'b1;
      end
      ASR: begin
        next_q    = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit   = q[0];
        out_valid = 1'b1;
      end
      default: ; // HOLD and reserved code 7 leave the register untouched
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with load/shift/rotate, driven either one op per enabled
// cycle (direct) or by a start/busy/done command repeating an op `amount` times.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic  clock,
  input logic  clear,
  usr_if.slave bus
);

  state_t           state;
  logic [2:0]       op;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] next_q;
  logic             out_bit;
  logic             out_valid;

  // In RUN the latched op drives the step; otherwise the live mode does.
  assign step_mode = (state == RUN) ? op : bus.mode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode      (step_mode),
    .q         (q_r),
    .serial_in (bus.serial_in),
    .load_data (bus.load_data),
    .next_q    (next_q),
    .out_bit   (out_bit),
    .out_valid (out_valid)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      op     <= HOLD;
      count  <= '0;
      q_r    <= '0;
      sout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op <= bus.mode;
            if (is_multi_step(bus.mode) && (bus.amount != '0)) begin
              count <= bus.amount;
              state <= RUN;
            end else begin
              if (bus.mode == LOAD) q_r <= next_q;
              state <= DONE;
            end
          end else if (bus.enable) begin
            q_r <= next_q;
            if (out_valid) sout_r <= out_bit;
          end
        end
        RUN: begin
          if (bus.enable) begin
            q_r   <= next_q;
            if (out_valid) sout_r <= out_bit;
            count <= count - 1'b1;
            if (count == AMT_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = sout_r;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed scenarios plus random traffic,
// every cycle compared against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic clock = 1'b0;
  logic clear;

  usr_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  universal_shift_register #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register value as an integer, phase 0=idle 1=run 2=done.
  int m_q     = 0;
  int m_so    = 0;
  int m_phase = 0;
  int m_rem   = 0;
  int m_op    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic void model_apply(input int op, input int sin, input int ld);
    case (op)
      1: m_q = ld;
      2: begin m_so = m_q / 128; m_q = (m_q * 2 + sin) % 256; end
      3: begin m_so = m_q % 2;   m_q = m_q / 2 + sin * 128; end
      4: begin m_so = m_q / 128; m_q = (m_q * 2) % 256 + m_so; end
      5: begin m_so = m_q % 2;   m_q = m_q / 2 + m_so * 128; end
      6: begin m_so = m_q % 2;   m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
      default: ;
    endcase
  endfunction

  function automatic void model_edge(input int clr, input int en, input int md, input int sin,
                                     input int ld, input int st, input int amt);
    if (clr != 0) begin
      m_q = 0; m_so = 0; m_phase = 0; m_rem = 0;
    end else if (m_phase == 0) begin
      if (st != 0) begin
        m_op = md;
        if (md >= 2 && md <= 6 && amt > 0) begin
          m_rem = amt; m_phase = 1;
        end else begin
          if (md == 1) m_q = ld;
          m_phase = 2;
        end
      end else if (en != 0) begin
        model_apply(md, sin, ld);
      end
    end else if (m_phase == 1) begin
      if (en != 0) begin
        model_apply(m_op, sin, ld);
        m_rem--;
        if (m_rem == 0) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  task automatic step(input bit clr, input bit en, input logic [2:0] md, input bit sin,
                      input logic [7:0] ld, input bit st, input logic [3:0] amt);
    clear         = clr;
    bus.enable    = en;
    bus.mode      = md;
    bus.serial_in = sin;
    bus.load_data = ld;
    bus.start     = st;
    bus.amount    = amt;
    model_edge(int'(clr), int'(en), int'(md), int'(sin), int'(ld), int'(st), int'(amt));
    @(posedge clock);
    #1;
    chk("q", 32'(bus.q), 32'(m_q));
    chk("serial_out", 32'(bus.serial_out), 32'(m_so));
    chk("busy", 32'(bus.busy), (m_phase == 1) ? 32'd1 : 32'd0);
    chk("done", 32'(bus.done), (m_phase == 2) ? 32'd1 : 32'd0);
  endtask

  // Enabled command cycles with junk mode/start/amount that must be ignored.
  task automatic run_steps(input int n, input bit sin);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)), sin, 8'($urandom), 1'b1, 4'($urandom));
  endtask

  initial begin
    // Clear wins over start+LOAD
    step(1, 1, 3'd1, 0, 8'hAA, 1, 4'd3);
    step(1, 1, 3'd1, 0, 8'hAA, 1, 4'd3);
    chk("clear_q", 32'(bus.q), 32'h00);
    chk("clear_busy", 32'(bus.busy), 32'd0);
    chk("clear_done", 32'(bus.done), 32'd0);

    // Direct ops
    step(0, 1, 3'd1, 0, 8'hB4, 0, 4'd0);
    step(0, 1, 3'd2, 1, 8'h00, 0, 4'd0);
    chk("shl_q", 32'(bus.q), 32'h69);
    chk("shl_so", 32'(bus.serial_out), 32'd1);
    step(0, 1, 3'd6, 0, 8'h00, 0, 4'd0);
    chk("asr_q", 32'(bus.q), 32'h34);
    chk("asr_so", 32'(bus.serial_out), 32'd1);
    step(0, 0, 3'd2, 1, 8'h00, 0, 4'd0);
    chk("stall_q", 32'(bus.q), 32'h34);

    // Command ROL by 3, then by WIDTH
    step(0, 1, 3'd1, 0, 8'h81, 0, 4'd0);
    step(0, 1, 3'd4, 0, 8'h00, 1, 4'd3);
    chk("rol_busy", 32'(bus.busy), 32'd1);
    run_steps(3, 0);
    chk("rol_q", 32'(bus.q), 32'h0C);
    chk("rol_done", 32'(bus.done), 32'd1);
    step(0, 1, 3'd0, 0, 8'h00, 1, 4'd5);
    chk("done_start_ignored", 32'(bus.busy), 32'd0);
    step(0, 1, 3'd4, 0, 8'h00, 1, 4'd8);
    run_steps(8, 0);
    chk("rol8_q", 32'(bus.q), 32'h0C);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);

    // SHR by 4 with a 2-cycle enable stall
    step(0, 1, 3'd1, 0, 8'hF0, 0, 4'd0);
    step(0, 1, 3'd3, 0, 8'h00, 1, 4'd4);
    run_steps(2, 0);
    step(0, 0, 3'd2, 1, 8'h00, 1, 4'd1);
    step(0, 0, 3'd2, 1, 8'h00, 1, 4'd1);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    run_steps(2, 0);
    chk("shr_q", 32'(bus.q), 32'h0F);
    chk("shr_done", 32'(bus.done), 32'd1);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);

    // amount=0 and command LOAD
    step(0, 1, 3'd4, 0, 8'h00, 1, 4'd0);
    chk("amt0_busy", 32'(bus.busy), 32'd0);
    chk("amt0_done", 32'(bus.done), 32'd1);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);
    step(0, 0, 3'd1, 0, 8'h5A, 1, 4'd2);
    chk("cmd_load_q", 32'(bus.q), 32'h5A);
    chk("cmd_load_done", 32'(bus.done), 32'd1);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);

    // Overlong SHL drains to the fill value
    step(0, 1, 3'd1, 0, 8'hFF, 0, 4'd0);
    step(0, 1, 3'd2, 0, 8'h00, 1, 4'd12);
    run_steps(12, 0);
    chk("shl12_q", 32'(bus.q), 32'h00);
    chk("shl12_so", 32'(bus.serial_out), 32'd0);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);

    // Clear in the middle of a command
    step(0, 1, 3'd1, 0, 8'hC3, 0, 4'd0);
    step(0, 1, 3'd4, 0, 8'h00, 1, 4'd5);
    run_steps(2, 0);
    step(1, 1, 3'd4, 0, 8'h00, 1, 4'd5);
    chk("midrun_clear_q", 32'(bus.q), 32'h00);
    chk("midrun_clear_busy", 32'(bus.busy), 32'd0);
    step(0, 0, 3'd0, 0, 8'h00, 0, 4'd0);
    chk("midrun_idle_busy", 32'(bus.busy), 32'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           1'($urandom),
           8'($urandom),
           ($urandom_range(0, 5) == 0),
           4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
